// File: rtl/carrier_ctrl_if.sv
// rtl/carrier_ctrl_if.sv - configuration write channel between host and carrier controller
interface carrier_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);
endinterface

// File: rtl/carrier_ctrl.sv
// rtl/carrier_ctrl.sv - triangular carrier run-time controller (shadow/active config, prescaler, period count)
// Optional watchdog built when CARRIER_CTRL_WDOG_EN is defined.
module carrier_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MA_W        = 8,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    carrier_ctrl_if.slave    cfg,
    input  logic             start,
    input  logic             stop,
    input  logic             valley,
    input  logic             peak,
    output logic             carrier_en,
    output logic             carrier_clr,
    output logic             tick,
    output logic [CNT_W-1:0] step_out,
    output logic [CNT_W-1:0] amp_out,
    output logic [MA_W-1:0]  ma_out,
    output logic             pending,
    output logic             upd_done,
    output logic [CNT_W-1:0] period_cnt,
    output logic             busy,
    output logic             fault
);

    localparam logic [CNT_W-1:0] STEP_RST = CNT_W'(1);
    localparam logic [CNT_W-1:0] AMP_RST  = CNT_W'(32767);
    localparam logic [MA_W-1:0]  MA_RST   = MA_W'(10);
    localparam logic [MA_W-1:0]  MA_MAX   = MA_W'(13);

    typedef enum logic [1:0] {IDLE, ARM, RUN, STOP_WAIT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] sh_step, sh_amp, sh_div, act_div, pre_cnt, step_wr;
    logic [MA_W-1:0]  sh_ma, ma_wr;
    logic             wr, wr_q, commit, tick_q, wd_trip;

    assign cfg.cfg_ready = ~reset & (state != ARM);
    assign wr            = cfg.cfg_valid & cfg.cfg_ready;
    assign step_wr       = (cfg.cfg_data == '0) ? STEP_RST : cfg.cfg_data;
    assign ma_wr         = (cfg.cfg_data[MA_W-1:0] > MA_MAX) ? MA_MAX : cfg.cfg_data[MA_W-1:0];

    assign carrier_en  = (state == RUN) || (state == STOP_WAIT);
    assign carrier_clr = (state == ARM);
    assign busy        = (state != IDLE);
    assign tick        = tick_q & carrier_en;

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                commit = wr_q;
                if (start) state_nx = ARM;
            end
            ARM: begin
                commit   = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                commit = valley & pending;
                if (start)     state_nx = ARM;
                else if (stop) state_nx = STOP_WAIT;
            end
            STOP_WAIT: begin
                commit = valley & pending;
                if (start)       state_nx = RUN;
                else if (valley) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (wd_trip) state_nx = start ? ARM : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            upd_done   <= 1'b0;
            pending    <= 1'b0;
            sh_step    <= STEP_RST;
            sh_amp     <= AMP_RST;
            sh_ma      <= MA_RST;
            sh_div     <= '0;
            step_out   <= STEP_RST;
            amp_out    <= AMP_RST;
            ma_out     <= MA_RST;
            act_div    <= '0;
            period_cnt <= '0;
            pre_cnt    <= '0;
            tick_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            wr_q     <= wr;
            upd_done <= commit;
            pending  <= wr | (pending & ~commit);
            // Active takes the shadow as it stood before any same-cycle write.
            if (commit) begin
                step_out <= sh_step;
                amp_out  <= sh_amp;
                ma_out   <= sh_ma;
                act_div  <= sh_div;
            end
            if (wr) begin
                case (cfg.cfg_addr)
                    2'd0:    sh_step <= step_wr;
                    2'd1:    sh_amp  <= cfg.cfg_data;
                    2'd2:    sh_ma   <= ma_wr;
                    default: sh_div  <= cfg.cfg_data;
                endcase
            end
            if (state == ARM)
                period_cnt <= '0;
            else if (valley && carrier_en)
                period_cnt <= period_cnt + 1'b1;
            // Prescaler restarts on every commit so a new divider starts a clean interval.
            if (commit || !carrier_en) begin
                pre_cnt <= '0;
                tick_q  <= 1'b0;
            end else if (pre_cnt == act_div) begin
                pre_cnt <= '0;
                tick_q  <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
                tick_q  <= 1'b0;
            end
        end
    end

`ifdef CARRIER_CTRL_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            fault_q;

    assign wd_trip = carrier_en & ~(valley | peak) & (wd_cnt == WD_W'(WDOG_CYCLES - 1));
    assign fault   = fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt  <= '0;
            fault_q <= 1'b0;
        end else begin
            if (!carrier_en || valley || peak || wd_trip)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
            if (start)        fault_q <= 1'b0;
            else if (wd_trip) fault_q <= 1'b1;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^{peak, (WDOG_CYCLES > 0)};
    assign wd_trip     = 1'b0;
    assign fault       = 1'b0;
`endif

endmodule

// File: doc/carrier_ctrl.md
Name: carrier_ctrl

Overview:
Run-time controller for the triangular carrier generator in the SPWM path. Holds shadow and active copies of the carrier configuration: step, amplitude, modulation index and prescaler divider. Sequences start, clear and stop of the carrier. Commits new configuration only at a carrier valley so the carrier never tears mid-period. Also generates the prescaled step enable and counts completed carrier periods.

Parameters:
CNT_W, 16, width of step, amplitude, divider and period counter
MA_W, 8, width of modulation index (scaled x10: 10 = 1.0)
WDOG_CYCLES, 1000000, watchdog timeout in clk cycles (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accept
cfg_addr  in  2  0=STEP, 1=AMPL, 2=MA, 3=DIV
cfg_data  in  CNT_W  write data (MA uses low MA_W bits)
start  in  1  start/restart pulse
stop  in  1  stop request pulse
valley  in  1  1-cycle pulse from carrier at bottom turn-around
peak  in  1  1-cycle pulse from carrier at top turn-around
carrier_en  out  1  carrier run enable
carrier_clr  out  1  1-cycle synchronous clear to carrier
tick  out  1  prescaled step enable
step_out  out  CNT_W  active step
amp_out  out  CNT_W  active amplitude
ma_out  out  MA_W  active modulation index
pending  out  1  shadow differs from active, commit outstanding
upd_done  out  1  1-cycle pulse on each commit
period_cnt  out  CNT_W  completed carrier periods
busy  out  1  state != IDLE
fault  out  1  watchdog fault (sticky)

Behaviour:
- Reset values:
  - state IDLE; carrier_en, carrier_clr, tick, upd_done, pending, fault = 0; period_cnt = 0; cfg_ready = 0 during reset, 1 afterwards.
  - Shadow and active registers: STEP = 1, AMPL = 32767, MA = 10, DIV = 0.
- Config write:
  - Accepted when cfg_valid & cfg_ready. cfg_ready is 1 in every state except ARM.
  - Write updates the shadow register and sets pending.
  - STEP write of 0 is stored as 1. MA write above 13 is saturated to 13.
- Commit: copies all shadow registers to active, clears pending, pulses upd_done on the next cycle. Commit occurs when:
  - in IDLE, on the cycle after any accepted write;
  - in ARM, always;
  - in RUN/STOP_WAIT, on a valley pulse with pending = 1.
- Write and commit in the same cycle: commit takes the old shadow; the new write lands in shadow; pending stays 1.
- State machine:
  - IDLE: carrier_en = 0. start -> ARM.
  - ARM (1 cycle): carrier_clr = 1, commit, period_cnt <= 0, prescaler cleared -> RUN.
  - RUN: carrier_en = 1.
    - stop -> STOP_WAIT.
    - start -> ARM (restart).
    - start and stop in the same cycle: start wins.
  - STOP_WAIT: carrier_en = 1 until valley.
    - On valley: carrier_en <= 0, -> IDLE. Pending commit is still applied on that valley.
    - start -> RUN (stop cancelled, no clear).
- Prescaler:
  - Counter runs only while carrier_en = 1.
  - tick = 1 for one cycle every active DIV + 1 clk cycles; DIV = 0 gives tick every cycle.
  - First tick is DIV + 1 cycles after entering RUN.
  - DIV change takes effect from the commit cycle; the counter resets at commit.
- period_cnt increments on each valley in RUN or STOP_WAIT and wraps from 2^CNT_W - 1 to 0.
- valley or peak while in IDLE is ignored.
- reset mid-operation returns every output to its reset value immediately.

Optional Feature:
CARRIER_CTRL_WDOG_EN
- Defined:
  - A counter of carrier_en cycles is cleared on each valley or peak.
  - When the count reaches WDOG_CYCLES: fault <= 1 (sticky), carrier_en <= 0, state -> IDLE.
  - fault clears only on reset or on start; start also re-arms through ARM.
- Undefined: fault is tied to 0 and no watchdog logic is built.

Test Plan:
- Reset, then read outputs -> step_out = 1, amp_out = 32767, ma_out = 10, carrier_en = 0, cfg_ready = 1, period_cnt = 0.
- In IDLE write STEP = 5, MA = 20 -> after commit step_out = 5, ma_out = 13, upd_done pulses once per write, pending = 0.
- start; DIV = 3 -> carrier_clr pulses 1 cycle; carrier_en = 1; tick every 4 clk.
- In RUN write AMPL = 1000 -> pending = 1 and amp_out unchanged through peak; on valley amp_out = 1000, upd_done pulses, period_cnt increments.
- stop in RUN, then 3 peaks/valleys later valley -> carrier_en drops the cycle after the first valley, busy = 0. Repeat with start during STOP_WAIT -> stays RUN, no carrier_clr.
- WDOG_EN with WDOG_CYCLES = 50: start, hold valley/peak low -> fault = 1 at cycle 50, carrier_en = 0; start -> fault = 0, ARM entered.
